// File: rtl/instr_issue_queue.sv
// Fetch-to-decode instruction buffer: circular queue with control-transfer predecode
// and branch/delay-slot pairing on the issue side.

package instr_issue_queue_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
    logic        is_branch;
  } iq_entry_t;

endpackage

module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               flush,
  input  logic [FETCH_WIDTH-1:0]             in_valid,
  input  logic [FETCH_WIDTH*32-1:0]          in_instr,
  input  logic [FETCH_WIDTH*32-1:0]          in_pc,
  input  logic [FETCH_WIDTH-1:0]             in_exc,
  output logic                               in_ready,
  output logic [ISSUE_WIDTH-1:0]             out_valid,
  output logic [ISSUE_WIDTH*32-1:0]          out_instr,
  output logic [ISSUE_WIDTH*32-1:0]          out_pc,
  output logic [ISSUE_WIDTH-1:0]             out_exc,
  output logic [ISSUE_WIDTH-1:0]             out_is_branch,
  output logic [ISSUE_WIDTH-1:0]             out_in_delay_slot,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   out_accept,
  output logic [CNT_W-1:0]                   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned IN_W  = $clog2(FETCH_WIDTH + 1);

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic [IN_W-1:0]  n_in;
  logic [IN_W-1:0]  n_push;
  logic             push_en;
  iq_entry_t        push_entry [FETCH_WIDTH];
  logic [PTR_W-1:0] rd_idx     [ISSUE_WIDTH];
  iq_entry_t        rd_entry   [ISSUE_WIDTH];

  // Free space is judged on the registered count only, so no path from out_accept.
  assign in_ready = (DEPTH - 32'(count_q)) >= FETCH_WIDTH;
  assign count    = count_q;

  // Length of the contiguous valid prefix starting at lane 0.
  always_comb begin : push_len
    logic run;
    run  = 1'b1;
    n_in = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      run = run & in_valid[i];
      if (run) n_in = n_in + IN_W'(1);
    end
  end

  assign push_en = in_ready && (n_in != '0) && !flush;
  assign n_push  = push_en ? n_in : '0;

  // Predecode control transfers; a faulting fetch is never treated as a branch.
  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      push_entry[i].instr     = in_instr[32*i +: 32];
      push_entry[i].pc        = in_pc[32*i +: 32];
      push_entry[i].exc       = in_exc[i];
      push_entry[i].is_branch = 1'b0;
      case (in_instr[32*i+26 +: 6])
        6'b000010, 6'b000011,
        6'b000100, 6'b000101,
        6'b000110, 6'b000111: push_entry[i].is_branch = 1'b1;
        6'b000001: begin
          case (in_instr[32*i+16 +: 5])
            5'b00000, 5'b00001,
            5'b10000, 5'b10001: push_entry[i].is_branch = 1'b1;
            default:            push_entry[i].is_branch = 1'b0;
          endcase
        end
        6'b000000: begin
          case (in_instr[32*i +: 6])
            6'b001000, 6'b001001: push_entry[i].is_branch = 1'b1;
            default:              push_entry[i].is_branch = 1'b0;
          endcase
        end
        default: push_entry[i].is_branch = 1'b0;
      endcase
      if (in_exc[i]) push_entry[i].is_branch = 1'b0;
    end
  end

  // Entry storage carries no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (push_en && (IN_W'(i) < n_in)) begin
        mem[tail_q + PTR_W'(i)] <= push_entry[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(out_accept);
      tail_q  <= tail_q + PTR_W'(n_push);
      count_q <= count_q + CNT_W'(n_push) - CNT_W'(out_accept);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      rd_idx[k]   = head_q + PTR_W'(k);
      rd_entry[k] = mem[rd_idx[k]];
    end
  end

  // Walk candidate lanes; a branch is shown only together with its delay slot.
  always_comb begin : present
    logic stop;
    logic pend;
    stop              = 1'b0;
    pend              = 1'b0;
    out_valid         = '0;
    out_in_delay_slot = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      if (!stop && (CNT_W'(k) < count_q)) begin
        if (pend) begin
          out_valid[k]         = 1'b1;
          out_in_delay_slot[k] = 1'b1;
          pend                 = 1'b0;
        end else if (rd_entry[k].is_branch) begin
          if ((k + 1 < ISSUE_WIDTH) && (CNT_W'(k + 1) < count_q)) begin
            out_valid[k] = 1'b1;
            pend         = 1'b1;
          end else begin
            stop = 1'b1;
          end
        end else begin
          out_valid[k] = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    out_instr     = '0;
    out_pc        = '0;
    out_exc       = '0;
    out_is_branch = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      out_instr[32*k +: 32] = rd_entry[k].instr;
      out_pc[32*k +: 32]    = rd_entry[k].pc;
      out_exc[k]            = rd_entry[k].exc;
      out_is_branch[k]      = rd_entry[k].is_branch;
    end
  end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- Parametrised fetch-to-decode instruction buffer for the MIPS pipeline.
- Decouples a FETCH_WIDTH-wide fetch stage from an ISSUE_WIDTH-wide decode stage through a DEPTH-entry circular queue.
- Predecodes control-transfer instructions and keeps each branch/jump in the same issue group as its delay slot.
- Tags delay-slot lanes and supports a single-cycle pipeline flush.

Parameters:
DEPTH, 16, queue entries; power of 2, >= 2*FETCH_WIDTH
FETCH_WIDTH, 2, instructions pushed per cycle (1..4)
ISSUE_WIDTH, 2, instructions presented per cycle (2..4; a branch plus its delay slot must fit in one group)
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
flush  in  1  discard all entries (exception/ERET/mispredict redirect)
in_valid  in  FETCH_WIDTH  per-lane push valid; only the contiguous prefix from lane 0 is used
in_instr  in  FETCH_WIDTH*32  instruction words, lane i at [32i+31:32i]
in_pc  in  FETCH_WIDTH*32  PC of each lane
in_exc  in  FETCH_WIDTH  fetch exception (AdEL/TLB) for the lane
in_ready  out  1  queue can take a full FETCH_WIDTH group this cycle
out_valid  out  ISSUE_WIDTH  lane presented; always a contiguous prefix from lane 0
out_instr  out  ISSUE_WIDTH*32  instruction word per lane
out_pc  out  ISSUE_WIDTH*32  PC per lane
out_exc  out  ISSUE_WIDTH  fetch exception per lane
out_is_branch  out  ISSUE_WIDTH  predecoded control transfer
out_in_delay_slot  out  ISSUE_WIDTH  lane is the delay slot of the preceding lane
out_accept  in  $clog2(ISSUE_WIDTH+1)  number of lanes consumed by decode this cycle; must be <= popcount(out_valid)
count  out  CNT_W  current occupancy

Behaviour:
- Storage: DEPTH entries of {instr, pc, exc, is_branch}. Head and tail pointers wrap modulo DEPTH. count is registered.
- Reset: resetn=0 at a rising edge sets head=tail=count=0. Next cycle: out_valid=0, in_ready=1, count=0. Entry contents need no reset.
- Push:
  - n_in = length of the contiguous 1-prefix of in_valid; a lane after the first 0 is ignored.
  - Accepted iff in_ready=1 and n_in>0. Entries are written at tail..tail+n_in-1 with wrap, then tail += n_in.
  - in_ready = (DEPTH - count >= FETCH_WIDTH), computed from registered count only. A same-cycle pop does not raise it (no comb path from out_accept).
- Pop: head += out_accept and count += n_push - out_accept in the same cycle. Push and pop are simultaneous and independent. Full and empty need no special case beyond in_ready and out_valid.
- Presentation is combinational from head and count. The candidate lanes are k = 0..min(count,ISSUE_WIDTH)-1.
- Predecode (at push; in_exc=1 forces is_branch=0):
  - opcode BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, J 000010, JAL 000011;
  - REGIMM 000001 with rt in {00000, 00001, 10000, 10001};
  - SPECIAL 000000 with funct JR 001000 or JALR 001001.
- Delay-slot pairing:
  - A branch at lane k that is not itself a delay slot is presented only if lane k+1 exists, i.e. k+1 < ISSUE_WIDTH and k+1 < count. Otherwise out_valid is truncated to lanes 0..k-1.
  - A branch at lane 0 with count=1 gives out_valid=0 (stall until the slot arrives).
  - Lane k+1 then has out_in_delay_slot=1. A branch in a delay slot is not paired again.
- Decode must not accept a branch without its delay slot. out_accept that splits a presented pair is illegal; the bench asserts on it.
- Flush: at the edge it sets head=tail=count=0. A push in the same cycle is dropped and out_accept is ignored. Next cycle: out_valid=0, in_ready=1. flush and resetn=0 together behave as reset.
- Outputs are undefined when out_valid is 0 for that lane; the bench does not check them.

Test Plan:
- Reset then idle: hold resetn=0 for 2 cycles, release -> count=0, out_valid=0, in_ready=1. Push nothing -> outputs stay unchanged.
- Streaming: push ADDU (0x00851021) @0xBFC00000 and ORI @0xBFC00004 every cycle with out_accept=2 -> count stays 2 after the first cycle, out_valid=2'b11, out_pc increments by 8 per cycle, no in_delay_slot.
- Branch pairing:
  - Push BEQ (0x10850003) @0x100, then wait 1 cycle before pushing its slot -> out_valid=0 while count=1.
  - Push the slot @0x104 -> out_valid=2'b11, out_is_branch=2'b01, out_in_delay_slot=2'b10.
- Branch at the last lane: queue holds ADDU, JR ($31, 0x03E00008), NOP -> first group out_valid=2'b01 (ADDU only). After accept=1 -> JR+NOP presented with in_delay_slot=2'b10.
- Full/wrap: DEPTH=16, push 8 groups of 2 with out_accept=0 -> count=16, in_ready=0, a further push is dropped. Pop 2 per cycle while pushing -> pointers wrap with PC order preserved across entry 15 to entry 0.
- Flush with simultaneous push: count=6, assert flush together with push valid=2'b11 and out_accept=2 -> next cycle count=0, out_valid=0. A later push of exc=1 with a BEQ encoding -> out_is_branch=0, out_exc=1.
